// File: rtl/stream_pkg.sv
// Shared helpers for the stream_* family of blocks.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package stream_pkg;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Default buffer depth and the pointer width that goes with it.
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int PTR_W          = clog2(DEF_FIFO_DEPTH);

endpackage

// File: rtl/stream_join_if.sv
// Handshake bundle for stream_join: two input streams (b, c), one joined output (a).
// Latency: n/a (wires only).
// Backpressure: carries the ready signal of each stream.
interface stream_join_if #(
  parameter int DATA_BW = 8
);
  logic [DATA_BW-1:0]   b_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [DATA_BW-1:0]   c_data;
  logic                 c_valid;
  logic                 c_ready;
  logic                 a_valid;
  logic [2*DATA_BW-1:0] a_data;
  logic                 a_ready;

  // Producer of b/c and consumer of a.
  modport master (
    output b_data, b_valid, c_data, c_valid, a_ready,
    input  b_ready, c_ready, a_valid, a_data
  );

  // The join block itself.
  modport slave (
    input  b_data, b_valid, c_data, c_valid, a_ready,
    output b_ready, c_ready, a_valid, a_data
  );
endinterface

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO with combinational head output.
// Latency: a pushed item is visible at dout from the next cycle.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module stream_sync_fifo
  import stream_pkg::*;
#(
  parameter int DATA_BW    = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_BW-1:0] din,
  input  logic               pop,
  output logic [DATA_BW-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int PW = clog2(FIFO_DEPTH);

  logic [DATA_BW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [PW:0]        r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == (PW+1)'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is don't-care while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end
endmodule

// File: rtl/stream_join.sv
// Joins streams b and c into a = {b, c}; one buffer per input absorbs branch skew.
// Latency: 2 cycles from simultaneous input fire to a_valid; 1 beat/cycle sustained.
// Backpressure: input readies are buffer-not-full only; output register holds while !a_ready.
module stream_join
  import stream_pkg::*;
#(
  parameter int DATA_BW    = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  stream_join_if.slave bus
);
  logic [DATA_BW-1:0]   w_b_head;
  logic [DATA_BW-1:0]   w_c_head;
  logic                 w_b_full;
  logic                 w_c_full;
  logic                 w_b_empty;
  logic                 w_c_empty;
  logic                 w_load;
  logic                 r_a_valid;
  logic [2*DATA_BW-1:0] r_a_data;

  assign bus.b_ready = !w_b_full;
  assign bus.c_ready = !w_c_full;
  assign bus.a_valid = r_a_valid;
  assign bus.a_data  = r_a_data;

  // Both heads pop together, so b and c items can never be mis-paired.
  assign w_load = !w_b_empty && !w_c_empty && (!r_a_valid || bus.a_ready);

  stream_sync_fifo #(
    .DATA_BW    (DATA_BW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.b_valid && !w_b_full),
    .din   (bus.b_data),
    .pop   (w_load),
    .dout  (w_b_head),
    .full  (w_b_full),
    .empty (w_b_empty)
  );

  stream_sync_fifo #(
    .DATA_BW    (DATA_BW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_c (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.c_valid && !w_c_full),
    .din   (bus.c_data),
    .pop   (w_load),
    .dout  (w_c_head),
    .full  (w_c_full),
    .empty (w_c_empty)
  );

  // Output register: load a fresh pair, drop valid after a fire with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
    end else if (w_load) begin
      r_a_valid <= 1'b1;
      r_a_data  <= {w_b_head, w_c_head};
    end else if (bus.a_ready) begin
      r_a_valid <= 1'b0;
    end
  end
endmodule
